// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: opcodes, the fetch NOP and the fetch FSM state type.
package fetch_stage_pkg;

  localparam logic [6:0]  OPC_JAL     = 7'b1101111;
  localparam logic [31:0] NOP_INSTR_C = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  function automatic logic is_jal(input logic [31:0] ir);
    return ir[6:0] == OPC_JAL;
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, single-outstanding imem handshake, fetch buffer and F->D register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = NOP_INSTR_C
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        STALL,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_TGT,
  input  logic [31:0] JAL,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  output logic [31:0] F_IR,
  output logic [31:0] F_PC,
  output logic        F_VALID,
  output logic [31:0] D_IR,
  output logic [31:0] D_PC,
  output logic        D_VALID
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic [31:0]  f_ir_q, f_ir_d;
  logic [31:0]  f_pc_q, f_pc_d;
  logic         f_valid_q, f_valid_d;
  logic [31:0]  d_ir_q, d_ir_d;
  logic [31:0]  d_pc_q, d_pc_d;
  logic         d_valid_q, d_valid_d;

  logic         adv;
  logic         issue;
  logic [31:0]  npc;
  logic [31:0]  fetch_addr;

  // A JAL in the buffer steers the successor fetch directly, so no flush is needed.
  always_comb begin
    npc        = is_jal(f_ir_q) ? JAL : f_pc_q + 32'd4;
    adv        = f_valid_q & ~STALL & ~REDIRECT;
    issue      = (state_q == IDLE) & ~REDIRECT & (~f_valid_q | adv);
    fetch_addr = (adv ? npc : pc_q) & ~32'h3;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // A redirect while waiting turns the in-flight response into one to be discarded.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (issue) state_d = WAIT;
      WAIT:    if (IMEM_RVALID) state_d = IDLE;
               else if (REDIRECT) state_d = DROP;
      DROP:    if (IMEM_RVALID) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    IMEM_REQ  = RST_N & issue;
    IMEM_ADDR = fetch_addr;
  end

  always_comb begin
    pc_d      = pc_q;
    req_pc_d  = req_pc_q;
    f_ir_d    = f_ir_q;
    f_pc_d    = f_pc_q;
    f_valid_d = f_valid_q;
    d_ir_d    = d_ir_q;
    d_pc_d    = d_pc_q;
    d_valid_d = d_valid_q;

    if (issue) req_pc_d = fetch_addr;

    // The buffer is always empty in WAIT, so a fill never collides with an advance.
    if ((state_q == WAIT) && IMEM_RVALID && !REDIRECT) begin
      f_ir_d    = IMEM_RDATA;
      f_pc_d    = req_pc_q;
      f_valid_d = 1'b1;
    end

    if (REDIRECT) begin
      pc_d      = REDIRECT_TGT & ~32'h3;
      f_valid_d = 1'b0;
      d_valid_d = 1'b0;
      d_ir_d    = NOP_INSTR;
    end else if (adv) begin
      d_pc_d    = f_pc_q;
      d_ir_d    = f_ir_q;
      d_valid_d = 1'b1;
      f_valid_d = 1'b0;
      pc_d      = npc;
    end else if (!STALL) begin
      d_valid_d = 1'b0;
      d_ir_d    = NOP_INSTR;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc_q      <= RESET_VECTOR;
      req_pc_q  <= 32'h0;
      f_ir_q    <= NOP_INSTR;
      f_pc_q    <= 32'h0;
      f_valid_q <= 1'b0;
      d_ir_q    <= NOP_INSTR;
      d_pc_q    <= 32'h0;
      d_valid_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      req_pc_q  <= req_pc_d;
      f_ir_q    <= f_ir_d;
      f_pc_q    <= f_pc_d;
      f_valid_q <= f_valid_d;
      d_ir_q    <= d_ir_d;
      d_pc_q    <= d_pc_d;
      d_valid_q <= d_valid_d;
    end
  end

  always_comb begin
    F_IR    = f_ir_q;
    F_PC    = f_pc_q;
    F_VALID = f_valid_q;
    D_IR    = d_ir_q;
    D_PC    = d_pc_q;
    D_VALID = d_valid_q;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed handshake/flush scenarios plus a randomized run against a program-order model.
module tb_fetch_stage;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  logic        CLK;
  logic        RST_N;
  logic        STALL;
  logic        REDIRECT;
  logic [31:0] REDIRECT_TGT;
  logic [31:0] JAL;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_RVALID;
  logic [31:0] IMEM_RDATA;
  logic [31:0] F_IR;
  logic [31:0] F_PC;
  logic        F_VALID;
  logic [31:0] D_IR;
  logic [31:0] D_PC;
  logic        D_VALID;

  fetch_stage dut (
    .CLK(CLK), .RST_N(RST_N), .STALL(STALL), .REDIRECT(REDIRECT),
    .REDIRECT_TGT(REDIRECT_TGT), .JAL(JAL),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
    .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA),
    .F_IR(F_IR), .F_PC(F_PC), .F_VALID(F_VALID),
    .D_IR(D_IR), .D_PC(D_PC), .D_VALID(D_VALID)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;

  rsp_t        pend[$];
  logic [31:0] mem_ovr [logic [31:0]];
  logic        rand_mem, rand_lat, rand_phase;
  logic        jal_force_en;
  logic [31:0] jal_force_val;
  int          lat, cyc, total, bad, retired;
  logic [31:0] exp_pc;
  logic        s_req, s_fvalid, s_dvalid;
  logic [31:0] s_addr, s_fir, s_fpc, s_dir, s_dpc;

  // Target generator: PC-relative offset taken from the upper instruction bits.
  function automatic logic [31:0] jal_fn(input logic [31:0] ir, input logic [31:0] pc);
    return pc + {{19{ir[31]}}, ir[31:21], 2'b00};
  endfunction

  assign JAL = jal_force_en ? jal_force_val : jal_fn(F_IR, F_PC);

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    if (mem_ovr.exists(a)) return mem_ovr[a];
    if (!rand_mem) return 32'h0000_0013;
    h = (a ^ 32'h5A5A_1234) * 32'h9E37_79B1;
    h = h ^ (h >> 15);
    if (h[3:0] < 4'd3) return {h[31:7], 7'h6F};
    return {h[31:7], 7'h33};
  endfunction

  // Program order: a JAL continues at its target, anything else at pc+4.
  function automatic logic [31:0] model_next(input logic [31:0] pc);
    logic [31:0] ir;
    ir = mem_word(pc);
    if (ir[6:0] == 7'h6F) return jal_force_en ? jal_force_val : jal_fn(ir, pc);
    return pc + 32'd4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cycle(input logic st, input logic rd, input logic [31:0] tgt);
    rsp_t r;
    STALL        = st;
    REDIRECT     = rd;
    REDIRECT_TGT = tgt;
    IMEM_RVALID  = 1'b0;
    IMEM_RDATA   = 32'h0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      IMEM_RVALID = 1'b1;
      IMEM_RDATA  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end
    #2;
    s_req = IMEM_REQ;   s_addr = IMEM_ADDR;
    s_fvalid = F_VALID; s_fir = F_IR; s_fpc = F_PC;
    s_dvalid = D_VALID; s_dir = D_IR; s_dpc = D_PC;
    if (s_req) begin
      if (rand_phase) begin
        chk("one_outstanding", 32'(pend.size()), 32'd0);
        chk("addr_align", 32'(s_addr[1:0]), 32'd0);
      end
      r.addr = s_addr;
      r.due  = cyc + (rand_lat ? int'($urandom_range(1, 3)) : lat);
      pend.push_back(r);
    end
    if (!RST_N) exp_pc = RESET_VECTOR;
    else if (s_dvalid && !st && !rd) begin
      chk("model_dpc", s_dpc, exp_pc);
      chk("model_dir", s_dir, mem_word(exp_pc));
      exp_pc = model_next(exp_pc);
      retired++;
    end else if (rd) exp_pc = tgt & ~32'h3;
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    repeat (3) cycle(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 8 && pend.size() > 0; i++) cycle(1'b0, 1'b0, 32'h0);
    mem_ovr.delete();
    RST_N = 1'b1;
  endtask

  task automatic wait_req(input int maxc, output logic [31:0] a, output logic ok);
    ok = 1'b0;
    a  = 32'h0;
    for (int i = 0; i < maxc && !ok; i++) begin
      cycle(1'b0, 1'b0, 32'h0);
      if (s_req) begin
        ok = 1'b1;
        a  = s_addr;
      end
    end
  endtask

  initial begin
    logic [31:0] a;
    logic        ok;
    logic        st, rd;
    RST_N = 1'b0; STALL = 1'b0; REDIRECT = 1'b0; REDIRECT_TGT = 32'h0;
    IMEM_RVALID = 1'b0; IMEM_RDATA = 32'h0;
    rand_mem = 1'b0; rand_lat = 1'b0; rand_phase = 1'b0;
    jal_force_en = 1'b0; jal_force_val = 32'h0;
    lat = 1; cyc = 0; total = 0; bad = 0; retired = 0; exp_pc = RESET_VECTOR;
    @(posedge CLK);
    #1;

    // Reset values
    repeat (3) cycle(1'b0, 1'b0, 32'h0);
    chk("rst_req", 32'(s_req), 32'd0);
    chk("rst_fvalid", 32'(s_fvalid), 32'd0);
    chk("rst_fir", s_fir, 32'h0000_0013);
    chk("rst_fpc", s_fpc, 32'h0);
    chk("rst_dvalid", 32'(s_dvalid), 32'd0);
    chk("rst_dir", s_dir, 32'h0000_0013);
    chk("rst_dpc", s_dpc, 32'h0);

    // Sequential fetch, 1-cycle memory: one instruction every 2 cycles
    lat = 1;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      cycle(1'b0, 1'b0, 32'h0);
      chk("t1_req", 32'(s_req), 32'(c % 2 == 0));
      if (c % 2 == 0) chk("t1_addr", s_addr, 32'(2 * c));
      chk("t1_dvalid", 32'(s_dvalid), 32'(c % 2 == 1 && c >= 3));
      if (c % 2 == 1 && c >= 3) chk("t1_dpc", s_dpc, 32'(2 * (c - 3)));
    end

    // JAL at 0x8 redirects fetch to the generator's target without a flush
    do_reset();
    mem_ovr[32'h8] = 32'h0100_006F;
    jal_force_en = 1'b1; jal_force_val = 32'h0000_0100;
    repeat (4) cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    chk("t2_addr8", s_addr, 32'h8);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    chk("t2_req_jal", 32'(s_req), 32'd1);
    chk("t2_addr_jal", s_addr, 32'h100);
    cycle(1'b0, 1'b0, 32'h0);
    chk("t2_dpc8", s_dpc, 32'h8);
    chk("t2_dir8", s_dir, 32'h0100_006F);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    chk("t2_dvalid_tgt", 32'(s_dvalid), 32'd1);
    chk("t2_dpc_tgt", s_dpc, 32'h100);
    jal_force_en = 1'b0;

    // STALL for 3 cycles with D and F both occupied
    do_reset();
    mem_ovr[32'h0] = 32'h0050_0093;
    repeat (3) cycle(1'b0, 1'b0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      cycle(1'b1, 1'b0, 32'h0);
      chk("t3_stall_req", 32'(s_req), 32'd0);
      chk("t3_stall_dvalid", 32'(s_dvalid), 32'd1);
      chk("t3_stall_dpc", s_dpc, 32'h0);
      chk("t3_stall_dir", s_dir, 32'h0050_0093);
      if (c > 0) chk("t3_stall_fpc", s_fpc, 32'h4);
    end
    cycle(1'b0, 1'b0, 32'h0);
    chk("t3_rel_req", 32'(s_req), 32'd1);
    chk("t3_rel_addr", s_addr, 32'h8);
    cycle(1'b0, 1'b0, 32'h0);
    chk("t3_rel_dpc", s_dpc, 32'h4);

    // REDIRECT during WAIT: late response is dropped, refetch from aligned target
    lat = 3;
    do_reset();
    cycle(1'b0, 1'b0, 32'h0);
    chk("t4_req0", 32'(s_req), 32'd1);
    cycle(1'b0, 1'b1, 32'h203);
    chk("t4_req_redir", 32'(s_req), 32'd0);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    chk("t4_req_drop", 32'(s_req), 32'd0);
    cycle(1'b0, 1'b0, 32'h0);
    chk("t4_req_tgt", 32'(s_req), 32'd1);
    chk("t4_addr_tgt", s_addr, 32'h200);
    chk("t4_fvalid", 32'(s_fvalid), 32'd0);
    chk("t4_dvalid", 32'(s_dvalid), 32'd0);
    chk("t4_dir", s_dir, 32'h0000_0013);
    repeat (4) cycle(1'b0, 1'b0, 32'h0);
    chk("t4_fill_valid", 32'(s_fvalid), 32'd1);
    chk("t4_fill_pc", s_fpc, 32'h200);

    // REDIRECT + STALL in the same cycle as the response
    lat = 2;
    do_reset();
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'h40);
    cycle(1'b0, 1'b0, 32'h0);
    chk("t5_fvalid", 32'(s_fvalid), 32'd0);
    chk("t5_req", 32'(s_req), 32'd1);
    chk("t5_addr", s_addr, 32'h40);
    chk("t5_dvalid", 32'(s_dvalid), 32'd0);

    // Reset mid-WAIT; stale response lands on the release cycle
    lat = 3;
    do_reset();
    mem_ovr[32'h0]   = 32'h00A0_0113;
    mem_ovr[32'h200] = 32'hABCD_E033;
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h200);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    chk("t6_addr_200", s_addr, 32'h200);
    RST_N = 1'b0;
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    RST_N = 1'b1;
    cycle(1'b0, 1'b0, 32'h0);
    chk("t6_restart_req", 32'(s_req), 32'd1);
    chk("t6_restart_addr", s_addr, RESET_VECTOR);
    cycle(1'b0, 1'b0, 32'h0);
    chk("t6_stale_fvalid", 32'(s_fvalid), 32'd0);
    chk("t6_stale_dvalid", 32'(s_dvalid), 32'd0);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    chk("t6_fill_valid", 32'(s_fvalid), 32'd1);
    chk("t6_fill_pc", s_fpc, 32'h0);
    chk("t6_fill_ir", s_fir, 32'h00A0_0113);
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC);
    wait_req(20, a, ok);
    chk("wrap_req_seen", 32'(ok), 32'd1);
    chk("wrap_addr_top", a, 32'hFFFF_FFFC);
    wait_req(20, a, ok);
    chk("wrap_req2_seen", 32'(ok), 32'd1);
    chk("wrap_addr_zero", a, 32'h0);
    repeat (6) cycle(1'b0, 1'b0, 32'h0);

    // Randomized run against the program-order model
    do_reset();
    rand_mem = 1'b1; rand_lat = 1'b1; rand_phase = 1'b1;
    retired = 0;
    for (int i = 0; i < 1200; i++) begin
      st = ($urandom % 4) == 0;
      rd = ($urandom % 12) == 0;
      cycle(st, rd, 32'($urandom_range(0, 1023)));
    end
    repeat (10) cycle(1'b0, 1'b0, 32'h0);
    chk("rand_progress", 32'(retired > 50), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
